// File: rtl/pipe_pkg.sv
// Shared types and helpers for the f-d-e-m-w pipeline stage buffers.
// Stages pack these payload structs into the flat pre_data bus of pipe_stage_buf.
package pipe_pkg;

  localparam int PERF_CW = 32;

  // Pointer width for a DEPTH-entry ring; a single-entry ring still needs one bit.
  function automatic int ptr_w(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_LUI  = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_op_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fd_payload_t;

  typedef struct packed {
    logic [31:0] pc;
    alu_op_e     alu_op;
    mem_op_e     mem_op;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] store_data;
  } de_payload_t;

  typedef struct packed {
    logic [31:0] pc;
    mem_op_e     mem_op;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] alu_result;
  } em_payload_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } mw_payload_t;

endpackage

// File: rtl/pipe_stage_perf.sv
// Saturating stall/bubble cycle counters observed on one pipeline stage buffer.
// Instantiated by pipe_stage_buf only when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_perf
  import pipe_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               reg_valid,
  input  logic               cur_stall,
  input  logic               post_allowin,
  output logic [PERF_CW-1:0] stall_cycles,
  output logic [PERF_CW-1:0] bubble_cycles
);

  logic               w_stall_evt;
  logic               w_bubble_evt;
  logic [PERF_CW-1:0] r_stall_cycles;
  logic [PERF_CW-1:0] r_bubble_cycles;

  assign w_stall_evt  = reg_valid && (cur_stall || !post_allowin);
  assign w_bubble_evt = !reg_valid && post_allowin;

  // Counters stick at all-ones rather than wrapping; flush does not touch them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cycles  <= '0;
      r_bubble_cycles <= '0;
    end else begin
      if (w_stall_evt && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + 1'b1;
      end
      if (w_bubble_evt && (r_bubble_cycles != '1)) begin
        r_bubble_cycles <= r_bubble_cycles + 1'b1;
      end
    end
  end

  assign stall_cycles  = r_stall_cycles;
  assign bubble_cycles = r_bubble_cycles;

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register: DEPTH-entry ring buffer with valid/allowin handshake,
// stall and flush. Define PIPE_STAGE_PERF_EN to add stall_cycles/bubble_cycles outputs.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 1,
  parameter int ALLOWIN_REG = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pre_valid,
  input  logic [WIDTH-1:0]           pre_data,
  output logic                       cur_allowin,
  input  logic                       cur_stall,
  input  logic                       flush,
  input  logic                       post_allowin,
  output logic                       goon_valid,
  output logic                       reg_valid,
  output logic [WIDTH-1:0]           data,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [PERF_CW-1:0]         stall_cycles,
  output logic [PERF_CW-1:0]         bubble_cycles
`endif
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wp;
  logic [PTR_W-1:0] r_rp;
  logic [CNT_W-1:0] r_cnt;

  logic             w_not_full;
  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_cnt_nxt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign reg_valid  = (r_cnt != '0);
  assign goon_valid = reg_valid && !cur_stall;
  assign w_not_full = (r_cnt < CNT_W'(DEPTH));
  assign w_pop      = goon_valid && post_allowin;
  assign w_push     = pre_valid && cur_allowin;

  // The registered variant drops the pop term so allowin never sees post_allowin.
  generate
    if (ALLOWIN_REG != 0) begin : g_allowin_reg
      assign cur_allowin = w_not_full;
    end else begin : g_allowin_comb
      assign cur_allowin = w_not_full || w_pop;
    end
  endgenerate

  // NOTE: the payload array has no reset; only occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wp] <= pre_data;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({w_push, w_pop})
      2'b10:   w_cnt_nxt = r_cnt + 1'b1;
      2'b01:   w_cnt_nxt = r_cnt - 1'b1;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wp <= ptr_inc(r_wp);
      end
      if (w_pop) begin
        r_rp <= ptr_inc(r_rp);
      end
      r_cnt <= w_cnt_nxt;
    end
  end

  assign data  = r_mem[r_rp];
  assign count = r_cnt;

`ifdef PIPE_STAGE_PERF_EN
  pipe_stage_perf u_perf (
    .clk          (clk),
    .reset        (reset),
    .reg_valid    (reg_valid),
    .cur_stall    (cur_stall),
    .post_allowin (post_allowin),
    .stall_cycles (stall_cycles),
    .bubble_cycles(bubble_cycles)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: three instances (D1/comb, D4/reg, D3/comb).
// Perf counter checks are compiled in when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_buf;

  logic clk;
  logic reset;

  // A: DEPTH=1, ALLOWIN_REG=0
  logic        a_pv, a_stall, a_flush, a_post;
  logic [31:0] a_pd, a_data;
  logic        a_allow, a_gv, a_rv;
  logic [0:0]  a_cnt;
  // B: DEPTH=4, ALLOWIN_REG=1
  logic        b_pv, b_stall, b_flush, b_post;
  logic [31:0] b_pd, b_data;
  logic        b_allow, b_gv, b_rv;
  logic [2:0]  b_cnt;
  // C: DEPTH=3, ALLOWIN_REG=0
  logic        c_pv, c_stall, c_flush, c_post;
  logic [31:0] c_pd, c_data;
  logic        c_allow, c_gv, c_rv;
  logic [1:0]  c_cnt;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] a_sc, a_bc, b_sc, b_bc, c_sc, c_bc;
`endif

  int n_checks = 0;
  int n_errors = 0;

  pipe_stage_buf #(.WIDTH(32), .DEPTH(1), .ALLOWIN_REG(0)) u_a (
    .clk(clk), .reset(reset), .pre_valid(a_pv), .pre_data(a_pd), .cur_allowin(a_allow),
    .cur_stall(a_stall), .flush(a_flush), .post_allowin(a_post), .goon_valid(a_gv),
    .reg_valid(a_rv), .data(a_data), .count(a_cnt)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cycles(a_sc), .bubble_cycles(a_bc)
`endif
  );

  pipe_stage_buf #(.WIDTH(32), .DEPTH(4), .ALLOWIN_REG(1)) u_b (
    .clk(clk), .reset(reset), .pre_valid(b_pv), .pre_data(b_pd), .cur_allowin(b_allow),
    .cur_stall(b_stall), .flush(b_flush), .post_allowin(b_post), .goon_valid(b_gv),
    .reg_valid(b_rv), .data(b_data), .count(b_cnt)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cycles(b_sc), .bubble_cycles(b_bc)
`endif
  );

  pipe_stage_buf #(.WIDTH(32), .DEPTH(3), .ALLOWIN_REG(0)) u_c (
    .clk(clk), .reset(reset), .pre_valid(c_pv), .pre_data(c_pd), .cur_allowin(c_allow),
    .cur_stall(c_stall), .flush(c_flush), .post_allowin(c_post), .goon_valid(c_gv),
    .reg_valid(c_rv), .data(c_data), .count(c_cnt)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cycles(c_sc), .bubble_cycles(c_bc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] q[$];
    int          m_cnt;
    int          n_push;
    int          n_pop;
    int          exp_stall;
    int          exp_bubble;
    logic        m_pop;
    logic        m_allow;

    reset = 1'b1;
    a_pv = 0; a_pd = '0; a_stall = 0; a_flush = 0; a_post = 0;
    b_pv = 0; b_pd = '0; b_stall = 0; b_flush = 0; b_post = 0;
    c_pv = 0; c_pd = '0; c_stall = 0; c_flush = 0; c_post = 0;
    #1;
    check("rst_a_rv",    32'(a_rv), 32'd0);
    check("rst_a_gv",    32'(a_gv), 32'd0);
    check("rst_a_cnt",   32'(a_cnt), 32'd0);
    check("rst_a_allow", 32'(a_allow), 32'd1);
    check("rst_b_allow", 32'(b_allow), 32'd1);
    check("rst_b_cnt",   32'(b_cnt), 32'd0);
    step();
    step();
    reset = 1'b0;

    // Single push and sustained 1/cycle through a one-entry stage
    step();
    a_pv = 1; a_pd = 32'hDEAD_BEEF; a_post = 1;
    #1;
    check("a_empty_allow", 32'(a_allow), 32'd1);
    check("a_no_passthru", 32'(a_rv), 32'd0);
    step();
    check("a_rv_1",    32'(a_rv), 32'd1);
    check("a_data_1",  a_data, 32'hDEAD_BEEF);
    check("a_cnt_1",   32'(a_cnt), 32'd1);
    check("a_allow_full_pop", 32'(a_allow), 32'd1);
    a_pd = 32'h1111_1111;
    step();
    check("a_data_2", a_data, 32'h1111_1111);
    check("a_cnt_2",  32'(a_cnt), 32'd1);
    a_pd = 32'h2222_2222;
    step();
    check("a_data_3", a_data, 32'h2222_2222);
    a_pv = 0;
    step();
    check("a_drain_rv", 32'(a_rv), 32'd0);
    a_post = 0;

    // Fill DEPTH=4 with registered allowin, fifth push refused
    b_post = 0; b_pv = 1;
    for (int i = 1; i <= 4; i++) begin
      b_pd = 32'(i);
      step();
    end
    check("b_full_cnt",   32'(b_cnt), 32'd4);
    check("b_full_allow", 32'(b_allow), 32'd0);
    b_pd = 32'd5;
    step();
    check("b_fifth_cnt",  32'(b_cnt), 32'd4);
    check("b_head",       b_data, 32'd1);
    b_pv = 0; b_post = 1;
    #1;
    check("b_full_allow_post", 32'(b_allow), 32'd0);
    check("b_gv", 32'(b_gv), 32'd1);
    step();
    check("b_pop1_data",  b_data, 32'd2);
    check("b_pop1_allow", 32'(b_allow), 32'd1);
    step();
    check("b_pop2_data", b_data, 32'd3);
    step();
    check("b_pop3_data", b_data, 32'd4);
    step();
    check("b_empty_cnt", 32'(b_cnt), 32'd0);
    check("b_empty_rv",  32'(b_rv), 32'd0);

    // Stall blocks pop but not push
    b_stall = 1; b_pv = 1; b_pd = 32'h10;
    step();
    b_pd = 32'h20;
    step();
    check("b_stall_gv",  32'(b_gv), 32'd0);
    check("b_stall_cnt", 32'(b_cnt), 32'd2);
    b_pd = 32'h30;
    step();
    b_pd = 32'h40;
    step();
    check("b_stall_fill",  32'(b_cnt), 32'd4);
    check("b_stall_allow", 32'(b_allow), 32'd0);
    b_pv = 0;
    step();
    check("b_stall_hold", 32'(b_cnt), 32'd4);
    b_stall = 0;
    #1;
    check("b_unstall_gv", 32'(b_gv), 32'd1);
    step();
    check("b_unstall_cnt",  32'(b_cnt), 32'd3);
    check("b_unstall_data", b_data, 32'h20);

    // Flush with a simultaneous accepted push
    b_post = 0; b_pv = 1; b_pd = 32'h99; b_flush = 1;
    #1;
    check("b_flush_allow", 32'(b_allow), 32'd1);
    step();
    check("b_flush_cnt", 32'(b_cnt), 32'd0);
    check("b_flush_rv",  32'(b_rv), 32'd0);
    b_flush = 0; b_pd = 32'h55;
    step();
    check("b_post_flush_cnt",  32'(b_cnt), 32'd1);
    check("b_post_flush_data", b_data, 32'h55);
    b_pd = 32'h66;
    step();
    check("b_pre_rst_cnt", 32'(b_cnt), 32'd2);
    b_pv = 0; b_post = 1;

    // Asynchronous reset between edges
    #3;
    reset = 1'b1;
    #1;
    check("b_arst_cnt",   32'(b_cnt), 32'd0);
    check("b_arst_rv",    32'(b_rv), 32'd0);
    check("b_arst_gv",    32'(b_gv), 32'd0);
    check("b_arst_allow", 32'(b_allow), 32'd1);
    reset = 1'b0;
    b_post = 0;

    // Wrap-around through DEPTH=3 with random downstream backpressure
    q = {};
    m_cnt = 0; n_push = 0; n_pop = 0; exp_stall = 0; exp_bubble = 0;
    step();
    for (int cyc = 0; cyc < 200 && n_pop < 10; cyc++) begin
      c_post = ($urandom_range(0, 2) != 0);
      c_pv   = (n_push < 10);
      c_pd   = 32'hC000_0000 + 32'(n_push);
      #1;
      m_pop   = (m_cnt > 0) && c_post;
      m_allow = (m_cnt < 3) || m_pop;
      check("c_allow", 32'(c_allow), 32'(m_allow));
      if (m_pop) check("c_order", c_data, q[0]);
      if ((m_cnt > 0) && !c_post) exp_stall++;
      if ((m_cnt == 0) && c_post) exp_bubble++;
      step();
      if (m_pop) begin
        void'(q.pop_front());
        n_pop++;
      end
      if (c_pv && m_allow) begin
        q.push_back(c_pd);
        n_push++;
      end
      m_cnt = q.size();
      check("c_cnt", 32'(c_cnt), 32'(m_cnt));
    end
    check("c_done", 32'(n_pop), 32'd10);
`ifdef PIPE_STAGE_PERF_EN
    check("c_stall_cycles",  c_sc, 32'(exp_stall));
    check("c_bubble_cycles", c_bc, 32'(exp_bubble));
`endif
    c_pv = 0; c_post = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
